chess_turn_ctrl: RTL and testbench
==================================

Name: chess_turn_ctrl

Overview:
- Game-sequencing controller for the chess clock.
- Decides which player's countdown runs, when it is decremented and when both counters are preset from the D switches.
- Detects flag fall, counts moves and handles pause/set mode.
- Sits between the user inputs (SELECT, STOP, Set_Impulse, D1..D8) and the two per-player time counters feeding the seven-segment drivers.

Parameters:
- DEFAULT_MIN, 5, minutes loaded into both counters on leaving reset (1..15).
- ZERO_NIB_MIN, 10, minutes loaded when a D nibble is 0.
- MOVE_W, 8, width of the move counter.
- INC_SEC, 2, seconds added per move (INCREMENT_EN only).

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- CLR  in  1  reset, synchronous, active-high.
- CE  in  1  global enable; when 0 the FSM and all counters hold and no strobes are issued.
- TICK  in  1  one-cycle 1 Hz strobe, qualified by CE.
- SELECT  in  1  side level: 0 = player0 running, 1 = player1 running.
- STOP  in  1  level; 1 = pause/set mode.
- Set_Impulse  in  1  load request, acted on at its rising edge.
- D  in  8  preset {D8..D1}; D[3:0] = player0 minutes, D[7:4] = player1 minutes.
- ZERO0, ZERO1  in  1  per-counter "time is 0:00" flags.
- DEC0, DEC1  out  1  one-cycle decrement strobes.
- LOAD0, LOAD1  out  1  one-cycle load strobes.
- LOAD_MIN0, LOAD_MIN1  out  4  minutes to load, valid with the matching LOAD strobe.
- ADD0, ADD1  out  1  one-cycle add-INC_SEC strobes (INCREMENT_EN only; tied 0 otherwise).
- ACTIVE  out  1  side currently charged.
- FLAG0, FLAG1  out  1  sticky flag-fall per player.
- MOVES  out  MOVE_W  completed handovers, saturating.
- STATE  out  3  FSM state encoding, for debug and display.

Behaviour:
- General: all outputs are registered. An input sampled at edge N produces its response at edge N+1. Inputs are already synchronous to CLK.
- Reset (CLR=1): state INIT; all strobes 0; LOAD_MIN0/1 = 0; FLAG0/1 = 0; MOVES = 0; ACTIVE = 0; SELECT/Set_Impulse history regs take the current inputs.
- INIT: one cycle, independent of CE. Issue LOAD0 = LOAD1 = 1 with LOAD_MIN0/1 = DEFAULT_MIN, then go to READY.
- READY:
  - ACTIVE follows SELECT.
  - CE=1 and STOP=0 -> RUN.
  - CE=1 and STOP=1 -> PAUSE.
- RUN:
  - TICK & CE -> DEC on ACTIVE side.
  - SELECT differs from its history reg -> handover: ACTIVE <= SELECT; MOVES++ (saturate at all-ones); with INCREMENT_EN, ADD strobe for the side just left.
  - ZERO of ACTIVE side = 1 -> FLAG; set FLAG0 or FLAG1.
  - STOP=1 -> PAUSE.
- PAUSE:
  - No DEC.
  - SELECT changes update ACTIVE but do not count as moves.
  - Set_Impulse rising edge -> LOAD0 = LOAD1 = 1 with nibble values (nibble 0 -> ZERO_NIB_MIN); MOVES = 0; FLAGs cleared.
  - STOP=0 -> RUN.
- FLAG: everything frozen. Only two exits:
  - STOP=1 and Set_Impulse rising edge -> load as in PAUSE, then go to PAUSE.
  - CLR.
- Priority within one cycle (first listed wins):
  - CLR.
  - ZERO of active side.
  - STOP.
  - Handover.
  - TICK.
- Simultaneous events:
  - TICK with a handover is charged to the old side.
  - TICK with STOP=1 issues no DEC.
  - ZERO with a handover goes to FLAG; no move is counted.
  - ZERO of the inactive side is ignored.
- CE=0:
  - State, ACTIVE and MOVES hold; no strobes.
  - History regs still update, so a SELECT toggle during CE=0 never produces a late handover.
- Set_Impulse held high produces exactly one load.
- Set_Impulse outside PAUSE or FLAG is ignored, though its edge history is still tracked.

Optional Feature:
- Macro CHESS_INCREMENT_EN.
- Defined: each RUN handover pulses ADD0 or ADD1 (side just left) for one cycle. The counter adds INC_SEC seconds.
- Undefined: ADD0/ADD1 are constant 0 and no increment logic is generated.

Decomposition:
- Package chess_pkg holds:
  - FSM state encoding: INIT=0, READY=1, RUN=2, PAUSE=3, FLAG=4.
  - DEFAULT_MIN, ZERO_NIB_MIN and INC_SEC defaults.
  - The nibble-to-minutes mapping function.
- One sub-module, chess_edge_det: single-register rising/any-edge detector, instanced for SELECT and Set_Impulse.

Test Plan:
- Reset and init: CLR=1 for 3 cycles, then 0 -> exactly one cycle of LOAD0=LOAD1=1 with LOAD_MIN=5; then READY; all FLAGs and MOVES = 0.
- Running and handovers:
  - CE=1, STOP=0, SELECT=0, 3 TICKs -> 3 DEC0 pulses, no DEC1.
  - Toggle SELECT 1, 0, 1 -> MOVES=3, ACTIVE=1.
  - TICK on the same cycle as the toggle -> DEC0, not DEC1.
- Pause and load:
  - STOP=1, D=8'h35, Set_Impulse held high 8 cycles -> exactly one load with LOAD_MIN0=5, LOAD_MIN1=3, MOVES=0.
  - D=8'h00 -> both LOAD_MIN = 10.
  - TICKs while STOP=1 -> no DEC.
- Flag fall:
  - RUN, ACTIVE=1, ZERO1=1 -> FLAG1=1, state FLAG; later TICK and SELECT toggles produce no strobes.
  - STOP=1 plus Set_Impulse -> FLAG1=0, state PAUSE.
  - ZERO0=1 while ACTIVE=1 -> no flag.
- CE gating: CE=0, toggle SELECT twice, pulse TICK -> no strobes, MOVES unchanged; CE=1 -> no phantom handover.
- CHESS_INCREMENT_EN: handover from side 0 to side 1 -> one ADD0 pulse; build without the macro -> ADD0/ADD1 stay 0.

Source files
------------

// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chess_pkg
// Brief   : Shared FSM encoding, timing defaults and preset-nibble mapping
//           for the chess clock turn controller.
// Revision: 1.0
// ============================================================================
package chess_pkg;

  localparam logic [2:0] c_st_init  = 3'd0;
  localparam logic [2:0] c_st_ready = 3'd1;
  localparam logic [2:0] c_st_run   = 3'd2;
  localparam logic [2:0] c_st_pause = 3'd3;
  localparam logic [2:0] c_st_flag  = 3'd4;

  localparam int c_default_min  = 5;
  localparam int c_zero_nib_min = 10;
  localparam int c_inc_sec      = 2;

  // A switch nibble of 0 would mean "no time at all", so it selects a fixed preset.
  function automatic logic [3:0] nib_to_min(input logic [3:0] nib, input logic [3:0] zero_min);
    return (nib == 4'd0) ? zero_min : nib;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chess_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : chess_edge_det
// Brief   : Single-register rising / any-edge detector.
// Revision: 1.0
// ============================================================================
module chess_edge_det (
  input  logic clk,
  input  logic i_d,
  output logic o_rise,
  output logic o_any
);

  logic r_prev;

  // History always tracks the input, even in reset, so leaving reset never shows an edge.
  always_ff @(posedge clk) begin
    r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;
  assign o_any  = i_d ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/chess_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : chess_turn_ctrl
// Brief   : Chess clock game sequencer: turn handover, decrement/load/add
//           strobes, flag fall, move count. Optional macro CHESS_INCREMENT_EN.
// Revision: 1.0
// ============================================================================
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int DEFAULT_MIN  = c_default_min,
  parameter int ZERO_NIB_MIN = c_zero_nib_min,
  parameter int MOVE_W       = 8,
  parameter int INC_SEC      = c_inc_sec
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              TICK,
  input  logic              SELECT,
  input  logic              STOP,
  input  logic              Set_Impulse,
  input  logic [7:0]        D,
  input  logic              ZERO0,
  input  logic              ZERO1,
  output logic              DEC0,
  output logic              DEC1,
  output logic              LOAD0,
  output logic              LOAD1,
  output logic [3:0]        LOAD_MIN0,
  output logic [3:0]        LOAD_MIN1,
  output logic              ADD0,
  output logic              ADD1,
  output logic              ACTIVE,
  output logic              FLAG0,
  output logic              FLAG1,
  output logic [MOVE_W-1:0] MOVES,
  output logic [2:0]        STATE
);

  localparam logic [3:0] c_default_nib = 4'(DEFAULT_MIN);
  localparam logic [3:0] c_zero_nib    = 4'(ZERO_NIB_MIN);

  logic              r_dec0, r_dec1, r_load0, r_load1, r_active, r_flag0, r_flag1;
  logic [3:0]        r_lmin0, r_lmin1;
  logic [MOVE_W-1:0] r_moves;
  logic [2:0]        r_state;

  logic w_sel_any, w_set_rise, w_sel_rise_unused, w_set_any_unused;
  logic w_zero_act, w_run_go, w_handover, w_load_req;

  chess_edge_det u_sel_edge (
    .clk    (CLK),
    .i_d    (SELECT),
    .o_rise (w_sel_rise_unused),
    .o_any  (w_sel_any)
  );

  chess_edge_det u_set_edge (
    .clk    (CLK),
    .i_d    (Set_Impulse),
    .o_rise (w_set_rise),
    .o_any  (w_set_any_unused)
  );

  assign w_zero_act = r_active ? ZERO1 : ZERO0;
  assign w_run_go   = (r_state == c_st_run) && CE && !w_zero_act && !STOP;
  assign w_handover = w_run_go && w_sel_any;
  assign w_load_req = CE && w_set_rise &&
                      ((r_state == c_st_pause) || ((r_state == c_st_flag) && STOP));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state  <= c_st_init;
      r_dec0   <= 1'b0;
      r_dec1   <= 1'b0;
      r_load0  <= 1'b0;
      r_load1  <= 1'b0;
      r_lmin0  <= 4'd0;
      r_lmin1  <= 4'd0;
      r_active <= 1'b0;
      r_flag0  <= 1'b0;
      r_flag1  <= 1'b0;
      r_moves  <= '0;
    end else begin
      r_dec0  <= 1'b0;
      r_dec1  <= 1'b0;
      r_load0 <= 1'b0;
      r_load1 <= 1'b0;
      if (r_state == c_st_init) begin
        r_load0 <= 1'b1;
        r_load1 <= 1'b1;
        r_lmin0 <= c_default_nib;
        r_lmin1 <= c_default_nib;
        r_state <= c_st_ready;
      end else if (CE) begin
        if (w_load_req) begin
          r_load0 <= 1'b1;
          r_load1 <= 1'b1;
          r_lmin0 <= nib_to_min(D[3:0], c_zero_nib);
          r_lmin1 <= nib_to_min(D[7:4], c_zero_nib);
          r_moves <= '0;
          r_flag0 <= 1'b0;
          r_flag1 <= 1'b0;
        end
        case (r_state)
          c_st_ready: begin
            r_active <= SELECT;
            r_state  <= STOP ? c_st_pause : c_st_run;
          end
          c_st_run: begin
            if (w_zero_act) begin
              r_state <= c_st_flag;
              if (r_active) r_flag1 <= 1'b1;
              else          r_flag0 <= 1'b1;
            end else if (STOP) begin
              r_state <= c_st_pause;
            end else begin
              // The tick is charged to the side that was running at this edge.
              if (TICK) begin
                r_dec0 <= ~r_active;
                r_dec1 <= r_active;
              end
              if (w_handover) begin
                r_active <= SELECT;
                if (r_moves != '1) r_moves <= r_moves + MOVE_W'(1);
              end
            end
          end
          c_st_pause: begin
            r_active <= SELECT;
            if (!STOP) r_state <= c_st_run;
          end
          c_st_flag: begin
            if (w_load_req) r_state <= c_st_pause;
          end
          default: r_state <= c_st_init;
        endcase
      end
    end
  end

`ifdef CHESS_INCREMENT_EN
  logic r_add0, r_add1;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_add0 <= 1'b0;
      r_add1 <= 1'b0;
    end else begin
      r_add0 <= w_handover && !r_active && (INC_SEC != 0);
      r_add1 <= w_handover &&  r_active && (INC_SEC != 0);
    end
  end

  assign ADD0 = r_add0;
  assign ADD1 = r_add1;
`else
  logic w_inc_unused;
  assign w_inc_unused = (INC_SEC != 0);
  assign ADD0 = 1'b0;
  assign ADD1 = 1'b0;
`endif

  assign DEC0      = r_dec0;
  assign DEC1      = r_dec1;
  assign LOAD0     = r_load0;
  assign LOAD1     = r_load1;
  assign LOAD_MIN0 = r_lmin0;
  assign LOAD_MIN1 = r_lmin1;
  assign ACTIVE    = r_active;
  assign FLAG0     = r_flag0;
  assign FLAG1     = r_flag1;
  assign MOVES     = r_moves;
  assign STATE     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_chess_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_chess_turn_ctrl
// Brief   : Self-checking bench for chess_turn_ctrl: directed steps followed by
//           random stimulus against a rule-level reference model.
// Revision: 1.0
// ============================================================================
module tb_chess_turn_ctrl;

  localparam int M_INIT = 0, M_READY = 1, M_RUN = 2, M_PAUSE = 3, M_FLAG = 4;

  logic       CLK = 1'b0;
  logic       CLR, CE, TICK, SELECT, STOP, Set_Impulse, ZERO0, ZERO1;
  logic [7:0] D;
  logic       DEC0, DEC1, LOAD0, LOAD1, ADD0, ADD1, ACTIVE, FLAG0, FLAG1;
  logic [3:0] LOAD_MIN0, LOAD_MIN1;
  logic [7:0] MOVES;
  logic [2:0] STATE;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   m_mode = M_INIT;
  int   m_moves = 0;
  logic m_active = 0, m_flag0 = 0, m_flag1 = 0, m_sel_h = 0, m_set_h = 0;
  logic e_dec0, e_dec1, e_load0, e_load1, e_add0, e_add1, m_lmin_chk;
  int   e_lmin0, e_lmin1;

  chess_turn_ctrl #(
    .DEFAULT_MIN (5),
    .ZERO_NIB_MIN(10),
    .MOVE_W      (8),
    .INC_SEC     (2)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .CE         (CE),
    .TICK       (TICK),
    .SELECT     (SELECT),
    .STOP       (STOP),
    .Set_Impulse(Set_Impulse),
    .D          (D),
    .ZERO0      (ZERO0),
    .ZERO1      (ZERO1),
    .DEC0       (DEC0),
    .DEC1       (DEC1),
    .LOAD0      (LOAD0),
    .LOAD1      (LOAD1),
    .LOAD_MIN0  (LOAD_MIN0),
    .LOAD_MIN1  (LOAD_MIN1),
    .ADD0       (ADD0),
    .ADD1       (ADD1),
    .ACTIVE     (ACTIVE),
    .FLAG0      (FLAG0),
    .FLAG1      (FLAG1),
    .MOVES      (MOVES),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int preset_min(input logic [3:0] nib);
    return (nib == 4'd0) ? 10 : int'(nib);
  endfunction

  task automatic model_load();
    e_load0 = 1; e_load1 = 1;
    e_lmin0 = preset_min(D[3:0]);
    e_lmin1 = preset_min(D[7:4]);
    m_lmin_chk = 1;
    m_moves = 0; m_flag0 = 0; m_flag1 = 0;
  endtask

  // One clock edge of the game rules, applied to the inputs sampled at that edge.
  task automatic model_step();
    logic set_rise, sel_chg, zero_act;
    set_rise = Set_Impulse & ~m_set_h;
    sel_chg  = SELECT ^ m_sel_h;
    zero_act = m_active ? ZERO1 : ZERO0;
    e_dec0 = 0; e_dec1 = 0; e_load0 = 0; e_load1 = 0; e_add0 = 0; e_add1 = 0;
    m_lmin_chk = 0;
    if (CLR) begin
      m_mode = M_INIT; m_active = 0; m_flag0 = 0; m_flag1 = 0; m_moves = 0;
      e_lmin0 = 0; e_lmin1 = 0; m_lmin_chk = 1;
    end else if (m_mode == M_INIT) begin
      e_load0 = 1; e_load1 = 1; e_lmin0 = 5; e_lmin1 = 5; m_lmin_chk = 1;
      m_mode = M_READY;
    end else if (CE) begin
      case (m_mode)
        M_READY: begin
          m_active = SELECT;
          m_mode = STOP ? M_PAUSE : M_RUN;
        end
        M_RUN: begin
          if (zero_act) begin
            if (m_active) m_flag1 = 1; else m_flag0 = 1;
            m_mode = M_FLAG;
          end else if (STOP) begin
            m_mode = M_PAUSE;
          end else begin
            if (TICK) begin
              if (m_active) e_dec1 = 1; else e_dec0 = 1;
            end
            if (sel_chg) begin
`ifdef CHESS_INCREMENT_EN
              if (m_active) e_add1 = 1; else e_add0 = 1;
`endif
              m_active = SELECT;
              if (m_moves < 255) m_moves++;
            end
          end
        end
        M_PAUSE: begin
          m_active = SELECT;
          if (set_rise) model_load();
          if (!STOP) m_mode = M_RUN;
        end
        M_FLAG: begin
          if (STOP && set_rise) begin
            model_load();
            m_mode = M_PAUSE;
          end
        end
        default: ;
      endcase
    end
    m_sel_h = SELECT;
    m_set_h = Set_Impulse;
  endtask

  task automatic check_all();
    chk("dec0", 32'(DEC0), 32'(e_dec0));
    chk("dec1", 32'(DEC1), 32'(e_dec1));
    chk("load0", 32'(LOAD0), 32'(e_load0));
    chk("load1", 32'(LOAD1), 32'(e_load1));
    chk("add0", 32'(ADD0), 32'(e_add0));
    chk("add1", 32'(ADD1), 32'(e_add1));
    chk("active", 32'(ACTIVE), 32'(m_active));
    chk("flag0", 32'(FLAG0), 32'(m_flag0));
    chk("flag1", 32'(FLAG1), 32'(m_flag1));
    chk("moves", 32'(MOVES), 32'(m_moves));
    chk("state", 32'(STATE), 32'(m_mode));
    if (m_lmin_chk) begin
      chk("load_min0", 32'(LOAD_MIN0), 32'(e_lmin0));
      chk("load_min1", 32'(LOAD_MIN1), 32'(e_lmin1));
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    CLR = 1; CE = 0; TICK = 0; SELECT = 0; STOP = 0; Set_Impulse = 0;
    D = 8'h00; ZERO0 = 0; ZERO1 = 0;
    #1;
    // reset and init
    cyc(3);
    CLR = 0;
    cyc(2);
    // running and handovers
    CE = 1;
    cyc(1);
    TICK = 1; cyc(3); TICK = 0;
    SELECT = 1; cyc(1);
    SELECT = 0; cyc(1);
    SELECT = 1; cyc(1);
    cyc(1);
    SELECT = 0; TICK = 1; cyc(1);
    SELECT = 1; cyc(1);
    TICK = 0; cyc(1);
    // pause and load
    STOP = 1; cyc(1);
    D = 8'h35; Set_Impulse = 1; cyc(8);
    Set_Impulse = 0; cyc(1);
    D = 8'h00; Set_Impulse = 1; cyc(1);
    Set_Impulse = 0; cyc(1);
    TICK = 1; cyc(3); TICK = 0;
    // flag fall
    STOP = 0; cyc(1);
    ZERO0 = 1; cyc(2); ZERO0 = 0;
    ZERO1 = 1; cyc(1); ZERO1 = 0;
    TICK = 1;
    for (int i = 0; i < 4; i++) begin SELECT = ~SELECT; cyc(1); end
    TICK = 0;
    STOP = 1; Set_Impulse = 1; cyc(1);
    Set_Impulse = 0; cyc(1);
    // CE gating
    STOP = 0; cyc(2);
    CE = 0;
    SELECT = ~SELECT; TICK = 1; cyc(1);
    SELECT = ~SELECT; cyc(1);
    TICK = 0; cyc(1);
    CE = 1; cyc(3);
    // zero together with a handover
    SELECT = ~SELECT; if (SELECT) ZERO0 = 1; else ZERO1 = 1; cyc(1);
    ZERO0 = 0; ZERO1 = 0;
    STOP = 1; Set_Impulse = 1; cyc(1);
    Set_Impulse = 0; STOP = 0; cyc(2);
    // move counter saturation
    for (int i = 0; i < 262; i++) begin SELECT = ~SELECT; cyc(1); end
    // random phase
    for (int i = 0; i < 3000; i++) begin
      CLR = ($urandom_range(0, 299) == 0);
      CE = ($urandom_range(0, 9) != 0);
      TICK = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) SELECT = ~SELECT;
      if ($urandom_range(0, 9) == 0) STOP = ~STOP;
      Set_Impulse = ($urandom_range(0, 3) == 0);
      D = 8'($urandom);
      ZERO0 = ($urandom_range(0, 39) == 0);
      ZERO1 = ($urandom_range(0, 39) == 0);
      cyc(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
